// File: rtl/bus_pkg.sv
// Shared types and widths for the two-master data-bus arbiter.
// Used by bus_arbiter and bus_arb_idfifo (optional feature macro: BUS_ARB_RR_EN).
package bus_pkg;

    localparam int ADDR_W = 14;
    localparam int DATA_W = 32;
    localparam int BE_W   = 4;

    // Requester identity carried through the outstanding-transfer FIFO.
    typedef logic req_id_t;

    localparam req_id_t ID_M0 = 1'b0;
    localparam req_id_t ID_M1 = 1'b1;

    typedef struct packed {
        logic              we;
        logic [BE_W-1:0]   be;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } bus_cmd_t;

endpackage

// File: rtl/bus_arb_idfifo.sv
// Outstanding-transfer ID FIFO: remembers which requester issued each accepted
// bus command so the in-order responses can be routed back.
module bus_arb_idfifo
    import bus_pkg::*;
#(
    parameter  int DEPTH = 2,
    localparam int CNT_W = $clog2(DEPTH + 1),
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push_i,
    input  req_id_t          push_id_i,
    input  logic             pop_i,
    output req_id_t          head_o,
    output logic [CNT_W-1:0] count_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    req_id_t          mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             push_ok;
    logic             pop_ok;

    assign full_o  = (count_o == FULL_CNT);
    assign empty_o = (count_o == '0);
    assign push_ok = push_i && !full_o;
    assign pop_ok  = pop_i && !empty_o;
    assign head_o  = mem[rd_ptr];

    function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] ptr);
        return (ptr == LAST_PTR) ? '0 : ptr + 1'b1;
    endfunction

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_o <= '0;
        end else begin
            if (push_ok) wr_ptr <= ptr_next(wr_ptr);
            if (pop_ok)  rd_ptr <= ptr_next(rd_ptr);
            // Simultaneous push and pop leaves the occupancy unchanged.
            if (push_ok && !pop_ok)      count_o <= count_o + 1'b1;
            else if (pop_ok && !push_ok) count_o <= count_o - 1'b1;
        end
    end

    // Entries beyond the occupancy are never read, so storage needs no reset.
    always_ff @(posedge clk_i) begin
        if (push_ok) mem[wr_ptr] <= push_id_i;
    end

endmodule

// File: rtl/bus_arbiter.sv
// Two-requester data-bus arbiter with in-order response routing.
// Define BUS_ARB_RR_EN for round-robin contention handling; default is fixed m0 priority.
module bus_arbiter
    import bus_pkg::*;
#(
    parameter int MAX_OUT = 2
) (
    input  logic              clk_i,
    input  logic              rst_ni,

    input  logic              m0_req_i,
    output logic              m0_gnt_o,
    input  logic              m0_we_i,
    input  logic [BE_W-1:0]   m0_be_i,
    input  logic [ADDR_W-1:0] m0_addr_i,
    input  logic [DATA_W-1:0] m0_wdata_i,
    output logic              m0_rvalid_o,
    output logic [DATA_W-1:0] m0_rdata_o,

    input  logic              m1_req_i,
    output logic              m1_gnt_o,
    input  logic              m1_we_i,
    input  logic [BE_W-1:0]   m1_be_i,
    input  logic [ADDR_W-1:0] m1_addr_i,
    input  logic [DATA_W-1:0] m1_wdata_i,
    output logic              m1_rvalid_o,
    output logic [DATA_W-1:0] m1_rdata_o,

    output logic              bus_req_o,
    output logic              bus_we_o,
    output logic [BE_W-1:0]   bus_be_o,
    output logic [ADDR_W-1:0] bus_addr_o,
    output logic [DATA_W-1:0] bus_wdata_o,
    input  logic              bus_rvalid_i,
    input  logic [DATA_W-1:0] bus_rdata_i,

    output logic              err_o
);

    localparam int CNT_W = $clog2(MAX_OUT + 1);

    bus_cmd_t         m0_cmd;
    bus_cmd_t         m1_cmd;
    bus_cmd_t         bus_cmd;
    logic             any_gnt;
    req_id_t          gnt_id;
    logic             prefer_m1;
    logic             fifo_pop;
    req_id_t          fifo_head;
    logic [CNT_W-1:0] fifo_count;
    logic             fifo_full;
    logic             fifo_empty;
    logic             spurious;

    assign m0_cmd = '{we: m0_we_i, be: m0_be_i, addr: m0_addr_i, wdata: m0_wdata_i};
    assign m1_cmd = '{we: m1_we_i, be: m1_be_i, addr: m1_addr_i, wdata: m1_wdata_i};

`ifdef BUS_ARB_RR_EN
    req_id_t last_id;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni)      last_id <= ID_M1;
        else if (any_gnt) last_id <= gnt_id;
    end

    assign prefer_m1 = (last_id == ID_M0);
`else
    assign prefer_m1 = 1'b0;
`endif

    // Full is taken from the registered count only, so a response in this
    // cycle never opens a slot combinationally.
    always_comb begin
        m0_gnt_o = 1'b0;
        m1_gnt_o = 1'b0;
        if (rst_ni && !fifo_full) begin
            if (m0_req_i && m1_req_i) begin
                m1_gnt_o = prefer_m1;
                m0_gnt_o = !prefer_m1;
            end else begin
                m0_gnt_o = m0_req_i;
                m1_gnt_o = m1_req_i;
            end
        end
    end

    assign any_gnt   = m0_gnt_o | m1_gnt_o;
    assign gnt_id    = m1_gnt_o ? ID_M1 : ID_M0;
    assign bus_req_o = any_gnt;

    assign bus_cmd     = m1_gnt_o ? m1_cmd : m0_cmd;
    assign bus_we_o    = bus_cmd.we;
    assign bus_be_o    = bus_cmd.be;
    assign bus_addr_o  = bus_cmd.addr;
    assign bus_wdata_o = bus_cmd.wdata;

    bus_arb_idfifo #(
        .DEPTH (MAX_OUT)
    ) u_idfifo (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .push_i    (any_gnt),
        .push_id_i (gnt_id),
        .pop_i     (fifo_pop),
        .head_o    (fifo_head),
        .count_o   (fifo_count),
        .full_o    (fifo_full),
        .empty_o   (fifo_empty)
    );

    assign fifo_pop = rst_ni && bus_rvalid_i && !fifo_empty;
    assign spurious = bus_rvalid_i && (fifo_count == '0);

    assign m0_rvalid_o = fifo_pop && (fifo_head == ID_M0);
    assign m1_rvalid_o = fifo_pop && (fifo_head == ID_M1);
    assign m0_rdata_o  = bus_rdata_i;
    assign m1_rdata_o  = bus_rdata_i;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni)       err_o <= 1'b0;
        else if (spurious) err_o <= 1'b1;
    end

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed bench for bus_arbiter: reset, contention, full, routing, push+pop, spurious response.
module tb_bus_arbiter;

    logic        clk = 1'b0;
    logic        rst_ni;
    logic        m0_req, m0_gnt, m0_we, m0_rvalid;
    logic [3:0]  m0_be;
    logic [13:0] m0_addr;
    logic [31:0] m0_wdata, m0_rdata;
    logic        m1_req, m1_gnt, m1_we, m1_rvalid;
    logic [3:0]  m1_be;
    logic [13:0] m1_addr;
    logic [31:0] m1_wdata, m1_rdata;
    logic        bus_req, bus_we, bus_rvalid, err;
    logic [3:0]  bus_be;
    logic [13:0] bus_addr;
    logic [31:0] bus_wdata, bus_rdata;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    bus_arbiter #(.MAX_OUT(2)) dut (
        .clk_i(clk), .rst_ni(rst_ni),
        .m0_req_i(m0_req), .m0_gnt_o(m0_gnt), .m0_we_i(m0_we), .m0_be_i(m0_be),
        .m0_addr_i(m0_addr), .m0_wdata_i(m0_wdata), .m0_rvalid_o(m0_rvalid), .m0_rdata_o(m0_rdata),
        .m1_req_i(m1_req), .m1_gnt_o(m1_gnt), .m1_we_i(m1_we), .m1_be_i(m1_be),
        .m1_addr_i(m1_addr), .m1_wdata_i(m1_wdata), .m1_rvalid_o(m1_rvalid), .m1_rdata_o(m1_rdata),
        .bus_req_o(bus_req), .bus_we_o(bus_we), .bus_be_o(bus_be), .bus_addr_o(bus_addr),
        .bus_wdata_o(bus_wdata), .bus_rvalid_i(bus_rvalid), .bus_rdata_i(bus_rdata),
        .err_o(err)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        m0_req = 0; m0_we = 0; m0_be = 4'hF; m0_addr = '0; m0_wdata = '0;
        m1_req = 0; m1_we = 0; m1_be = 4'hF; m1_addr = '0; m1_wdata = '0;
        bus_rvalid = 0; bus_rdata = '0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        idle();
        rst_ni = 0;
        @(negedge clk);
        rst_ni = 1;
    endtask

`ifdef BUS_ARB_RR_EN
    bit exp_m0 [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
`else
    bit exp_m0 [4] = '{1'b1, 1'b1, 1'b1, 1'b1};
`endif

    initial begin
        idle();
        rst_ni = 0;
        repeat (2) @(negedge clk);
        rst_ni = 1;

        // Reset mid-traffic: one transfer outstanding, both requesting, response arriving.
        @(negedge clk);
        m0_req = 1; m0_addr = 14'h0010;
        #1 check("pre_reset_gnt", m0_gnt, 1);
        @(negedge clk);
        m1_req = 1; bus_rvalid = 1;
        rst_ni = 0;
        #1;
        check("rst_m0_gnt", m0_gnt, 0);
        check("rst_m1_gnt", m1_gnt, 0);
        check("rst_bus_req", bus_req, 0);
        check("rst_m0_rvalid", m0_rvalid, 0);
        check("rst_m1_rvalid", m1_rvalid, 0);
        check("rst_err", err, 0);
        check("rst_count", dut.u_idfifo.count_o, 0);
        @(negedge clk);
        idle();
        rst_ni = 1;

        // Test 1: m0 read @0x0010, 1-cycle slave response.
        @(negedge clk);
        m0_req = 1; m0_we = 0; m0_addr = 14'h0010;
        #1;
        check("t1_gnt", m0_gnt, 1);
        check("t1_bus_req", bus_req, 1);
        check("t1_bus_addr", bus_addr, 14'h0010);
        check("t1_bus_we", bus_we, 0);
        @(negedge clk);
        m0_req = 0; bus_rvalid = 1; bus_rdata = 32'h11223344;
        #1;
        check("t1_m0_rvalid", m0_rvalid, 1);
        check("t1_m1_rvalid", m1_rvalid, 0);
        check("t1_rdata", m0_rdata, 32'h11223344);
        @(negedge clk);
        idle();
        #1;
        check("t1_count", dut.u_idfifo.count_o, 0);
        check("t1_err", err, 0);

        // Test 2: contention for 4 cycles, slave answers one cycle after each grant.
        do_reset();
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            m0_req = 1; m0_addr = 14'h0040;
            m1_req = 1; m1_addr = 14'h0080;
            bus_rvalid = (i > 0);
            #1;
            check($sformatf("t2_m0_gnt_%0d", i), m0_gnt, exp_m0[i]);
            check($sformatf("t2_m1_gnt_%0d", i), m1_gnt, !exp_m0[i]);
            check($sformatf("t2_addr_%0d", i), bus_addr, exp_m0[i] ? 14'h0040 : 14'h0080);
            if (i > 0) begin
                check($sformatf("t2_m0_rv_%0d", i), m0_rvalid, exp_m0[i-1]);
                check($sformatf("t2_m1_rv_%0d", i), m1_rvalid, !exp_m0[i-1]);
            end
        end
        @(negedge clk);
        m0_req = 0; bus_rvalid = 1;
        #1;
        check("t2_m1_after_drop", m1_gnt, 1);
        check("t2_m0_after_drop", m0_gnt, 0);
        check("t2_m0_rv_last", m0_rvalid, exp_m0[3]);
        @(negedge clk);
        m1_req = 0; bus_rvalid = 1;
        #1 check("t2_m1_rv_final", m1_rvalid, 1);
        @(negedge clk);
        idle();
        #1 check("t2_count", dut.u_idfifo.count_o, 0);

        // Test 3: full with 3-cycle slave latency, m1 back-to-back.
        do_reset();
        @(negedge clk);
        m1_req = 1; m1_addr = 14'h0200;
        #1 check("t3_gnt_c1", m1_gnt, 1);
        @(negedge clk);
        #1 check("t3_gnt_c2", m1_gnt, 1);
        @(negedge clk);
        #1;
        check("t3_gnt_full", m1_gnt, 0);
        check("t3_bus_req_full", bus_req, 0);
        @(negedge clk);
        bus_rvalid = 1;
        #1;
        check("t3_gnt_pop_cycle", m1_gnt, 0);
        check("t3_rv_c4", m1_rvalid, 1);
        @(negedge clk);
        #1;
        check("t3_gnt_after_pop", m1_gnt, 1);
        check("t3_rv_c5", m1_rvalid, 1);
        @(negedge clk);
        m1_req = 0; bus_rvalid = 0;
        @(negedge clk);
        #1 check("t3_count_mid", dut.u_idfifo.count_o, 1);
        @(negedge clk);
        bus_rvalid = 1;
        #1 check("t3_rv_c8", m1_rvalid, 1);
        @(negedge clk);
        idle();
        #1 check("t3_count_end", dut.u_idfifo.count_o, 0);

        // Test 4: routing of read (m0) then write (m1) responses.
        do_reset();
        @(negedge clk);
        m0_req = 1; m0_we = 0; m0_addr = 14'h2004;
        #1;
        check("t4_m0_gnt", m0_gnt, 1);
        check("t4_addr0", bus_addr, 14'h2004);
        @(negedge clk);
        m0_req = 0;
        m1_req = 1; m1_we = 1; m1_addr = 14'h0100; m1_be = 4'h3; m1_wdata = 32'hCAFEF00D;
        #1;
        check("t4_m1_gnt", m1_gnt, 1);
        check("t4_we", bus_we, 1);
        check("t4_addr1", bus_addr, 14'h0100);
        check("t4_be", bus_be, 4'h3);
        check("t4_wdata", bus_wdata, 32'hCAFEF00D);
        @(negedge clk);
        m1_req = 0; bus_rvalid = 1; bus_rdata = 32'hDEADBEEF;
        #1;
        check("t4_m0_rv", m0_rvalid, 1);
        check("t4_m1_rv_quiet", m1_rvalid, 0);
        check("t4_rdata", m0_rdata, 32'hDEADBEEF);
        @(negedge clk);
        bus_rdata = 32'h0;
        #1;
        check("t4_m1_rv", m1_rvalid, 1);
        check("t4_m0_rv_quiet", m0_rvalid, 0);
        @(negedge clk);
        idle();

        // Test 5: push and pop in the same cycle with one transfer outstanding.
        do_reset();
        @(negedge clk);
        m0_req = 1; m0_addr = 14'h0020;
        #1 check("t5_m0_gnt", m0_gnt, 1);
        @(negedge clk);
        m0_req = 0; m1_req = 1; m1_addr = 14'h0024; bus_rvalid = 1;
        #1;
        check("t5_m1_gnt", m1_gnt, 1);
        check("t5_m0_rv", m0_rvalid, 1);
        check("t5_m1_rv_quiet", m1_rvalid, 0);
        @(negedge clk);
        m1_req = 0;
        #1;
        check("t5_count", dut.u_idfifo.count_o, 1);
        check("t5_m1_rv", m1_rvalid, 1);
        check("t5_m0_rv_quiet", m0_rvalid, 0);
        @(negedge clk);
        idle();
        #1 check("t5_count_end", dut.u_idfifo.count_o, 0);

        // Test 6: spurious response sets a sticky error.
        @(negedge clk);
        bus_rvalid = 1;
        #1;
        check("t6_m0_rv", m0_rvalid, 0);
        check("t6_m1_rv", m1_rvalid, 0);
        check("t6_err_before", err, 0);
        @(negedge clk);
        bus_rvalid = 0;
        #1 check("t6_err_set", err, 1);
        repeat (3) @(negedge clk);
        #1 check("t6_err_sticky", err, 1);
        rst_ni = 0;
        #1 check("t6_err_cleared", err, 0);
        @(negedge clk);
        rst_ni = 1;
        @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
